// File: rtl/muldiv_pkg.sv
// Shared types and default sizing for the sequential multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_REG_BITS = 3;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one 2*WIDTH shift register.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV requests complete at once with err_o.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [REG_BITS-1:0] dest_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                writeFlag_o,
  output logic                overFlag_o,
  output logic [REG_BITS-1:0] destReg_o,
  output logic [WIDTH-1:0]    data_o,
  output logic [WIDTH-1:0]    over_o,
  output logic                err_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]      b_q;
  logic [REG_BITS-1:0]   dest_q;
  logic [WIDTH-1:0]      data_q, over_q;
  logic                  ovf_q, err_q;

  op_e                   op_in;
  logic                  accept, reject, last;
  logic [WIDTH:0]        mul_sum;
  logic [2*WIDTH-1:0]    mul_next, step_next;
  logic                  step_ovf;

  assign op_in  = op_e'(op_i);
  assign accept = (state_q == IDLE) && start_i;
  assign last   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // Multiply step: conditionally add b into the high half, then shift right one bit.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  op_e            op_q;
  logic [WIDTH:0] div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Restoring divide: high half holds the remainder, low half shifts dividend out and quotient in.
  assign div_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign reject    = (op_in == OP_DIV) && (b_i == '0);
  assign step_next = (op_q == OP_DIV) ? div_next : mul_next;
  assign step_ovf  = (op_q == OP_DIV) ? 1'b1 : (|mul_next[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (accept) op_q <= op_in;
  end
`else
  assign reject    = (op_in == OP_DIV);
  assign step_next = mul_next;
  assign step_ovf  = |mul_next[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = reject ? DONE : RUN;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, a_i};
        end
      end
      RUN: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (accept) b_q <= b_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      data_q  <= '0;
      over_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dest_q <= dest_i;
        err_q  <= reject;
        if (reject) begin
          data_q <= '1;
          over_q <= a_i;
          ovf_q  <= 1'b0;
        end
      end
      if (last) begin
        data_q <= step_next[WIDTH-1:0];
        over_q <= step_next[2*WIDTH-1:WIDTH];
        ovf_q  <= step_ovf;
      end
    end
  end

  // Write enables exist only while DONE, so an async reset cancels any pending write.
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = done_o && err_q;
  assign writeFlag_o = done_o && !err_q;
  assign overFlag_o  = writeFlag_o && ovf_q && (dest_q != '1);
  assign destReg_o   = dest_q;
  assign data_o      = data_q;
  assign over_o      = over_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations queue expected results, a negedge monitor checks them.
module tb_muldiv_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       op_i;
  logic [7:0] a_i, b_i;
  logic [2:0] dest_i;
  logic       busy_o, done_o, writeFlag_o, overFlag_o, err_o;
  logic [2:0] destReg_o;
  logic [7:0] data_o, over_o;

  typedef struct {
    logic [7:0] data;
    logic [7:0] over;
    logic       wf;
    logic       of;
    logic       err;
    logic [2:0] dest;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .dest_i     (dest_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .writeFlag_o(writeFlag_o),
    .overFlag_o (overFlag_o),
    .destReg_o  (destReg_o),
    .data_o     (data_o),
    .over_o     (over_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completion against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done_o) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("data", {24'd0, data_o}, {24'd0, e.data});
          chk("over", {24'd0, over_o}, {24'd0, e.over});
          chk("writeFlag", {31'd0, writeFlag_o}, {31'd0, e.wf});
          chk("overFlag", {31'd0, overFlag_o}, {31'd0, e.of});
          chk("err", {31'd0, err_o}, {31'd0, e.err});
          chk("destReg", {29'd0, destReg_o}, {29'd0, e.dest});
        end
      end else if (writeFlag_o || overFlag_o || err_o) begin
        chk("flags_outside_done", {29'd0, writeFlag_o, overFlag_o, err_o}, 32'd0);
      end
    end
  end

  // Drives one request for a single cycle; the done pulse is expected lat edges after the accepting edge.
  task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] dest, input logic [7:0] ed, input logic [7:0] eo,
                       input logic ewf, input logic eof, input logic eerr, input int lat);
    exp_t x;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    dest_i  = dest;
    x.data = ed; x.over = eo; x.wf = ewf; x.of = eof; x.err = eerr; x.dest = dest;
    x.cyc  = cyc + 1 + lat;
    q.push_back(x);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !busy_o) return;
      @(negedge clk);
    end
    chk("timeout", 32'd1, 32'd0);
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0; dest_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {8'd0, busy_o, done_o, writeFlag_o, overFlag_o, err_o, destReg_o, data_o, over_o}, 32'd0);
    rst_n = 1'b1;

    // 15*17 = 0x00FF, with start pulses and a_i changes while RUN is in progress.
    issue(1'b0, 8'd15, 8'd17, 3'd2, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8);
    @(negedge clk);
    start_i = 1'b1; a_i = 8'd1; b_i = 8'd1; dest_i = 3'd5;
    @(negedge clk);
    start_i = 1'b0; a_i = 8'hAA;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();

    // 200*3 = 0x0258; dest 7 suppresses the high-half write.
    issue(1'b0, 8'd200, 8'd3, 3'd1, 8'h58, 8'h02, 1'b1, 1'b1, 1'b0, 8);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_data", {24'd0, data_o}, 32'h58);
    chk("hold_over", {24'd0, over_o}, 32'h02);
    chk("hold_dest", {29'd0, destReg_o}, 32'd1);
    issue(1'b0, 8'd200, 8'd3, 3'd7, 8'h58, 8'h02, 1'b1, 1'b0, 1'b0, 8);
    wait_idle();
    issue(1'b0, 8'd255, 8'd255, 3'd4, 8'h01, 8'hFE, 1'b1, 1'b1, 1'b0, 8);
    wait_idle();
    issue(1'b0, 8'd0, 8'd99, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8);
    wait_idle();

`ifdef MULDIV_DIV_EN
    issue(1'b1, 8'd100, 8'd7, 3'd6, 8'h0E, 8'h02, 1'b1, 1'b1, 1'b0, 8);
    wait_idle();
    issue(1'b1, 8'd255, 8'd16, 3'd2, 8'h0F, 8'h0F, 1'b1, 1'b1, 1'b0, 8);
    wait_idle();
    issue(1'b1, 8'd5, 8'd9, 3'd1, 8'h00, 8'h05, 1'b1, 1'b1, 1'b0, 8);
    wait_idle();
`else
    issue(1'b1, 8'd100, 8'd7, 3'd6, 8'hFF, 8'h64, 1'b0, 1'b0, 1'b1, 0);
    wait_idle();
`endif
    issue(1'b1, 8'h35, 8'd0, 3'd5, 8'hFF, 8'h35, 1'b0, 1'b0, 1'b1, 0);
    wait_idle();

    // Reset during RUN cycle 4: the pending result must never appear.
    issue(1'b0, 8'd200, 8'd3, 3'd1, 8'h58, 8'h02, 1'b1, 1'b1, 1'b0, 8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run",
        {8'd0, busy_o, done_o, writeFlag_o, overFlag_o, err_o, destReg_o, data_o, over_o}, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_reset", {31'd0, busy_o}, 32'd0);
    issue(1'b0, 8'd2, 8'd2, 3'd3, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
